// File: rtl/bus_slave.sv
// bus_slave: word-addressed memory slave with a fixed number of wait states per transaction
module bus_slave #(
    parameter int DEPTH = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        a_ready,
    output logic        d_ready,
    output logic [31:0] rdata,
    output logic        backpressure
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = WAIT_CYCLES > 0 ? 4'(WAIT_CYCLES - 1) : 4'd0;
    typedef enum logic [1:0] {IDLE, WAIT, DATA} state_t;
    state_t state, state_nx;
    logic [3:0] cnt;
    logic wr_q;
    logic [AW-1:0] idx_q;
    logic [31:0] wdata_q;
    logic [31:0] mem [DEPTH];
    logic accept, cur_wr, unused;
    logic [AW-1:0] cur_idx;
    assign unused = ^{req_addr[31:AW+2], req_addr[1:0]};
    assign a_ready = state == IDLE && !reset;
    assign d_ready = state == DATA;
    assign backpressure = state != IDLE;
    assign accept = req_valid && a_ready;
    assign cur_wr = state == IDLE ? req_write : wr_q;
    assign cur_idx = state == IDLE ? req_addr[AW+1:2] : idx_q;
    always_comb begin
        state_nx = state;
        if (state == IDLE && accept) state_nx = WAIT_CYCLES > 0 ? WAIT : DATA;
        else if (state == WAIT && cnt == 4'd0) state_nx = DATA;
        else if (state == DATA) state_nx = IDLE;
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_nx;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            cnt <= '0;
            wr_q <= 1'b0;
            idx_q <= '0;
            wdata_q <= '0;
            rdata <= '0;
        end else begin
            if (accept) begin
                cnt <= CNT_INIT;
                wr_q <= req_write;
                idx_q <= req_addr[AW+1:2];
                wdata_q <= req_wdata;
            end else if (state == WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
            if (state_nx == DATA && state != DATA && !cur_wr) rdata <= mem[cur_idx];
        end
    always_ff @(posedge clk or posedge reset)
        if (reset) for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        else if (state == DATA && wr_q) mem[idx_q] <= wdata_q;
endmodule

// File: tb/tb_bus_slave.sv
// tb_bus_slave: randomized and directed checks of bus_slave against a cycles-remaining model
module tb_bus_slave;
    localparam int W = 2;
    localparam int DEPTH = 64;
    logic clk = 1'b0, reset = 1'b1;
    logic req_valid = 1'b0, req_write = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic a_ready, d_ready, backpressure;
    logic [31:0] rdata;
    logic v0 = 1'b0, w0 = 1'b0;
    logic [31:0] a0 = '0, wd0 = '0;
    logic ar0, dr0, bp0;
    logic [31:0] rd0;
    int n_chk = 0, n_fail = 0;
    logic started = 1'b0;
    bus_slave #(.DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .a_ready(a_ready),
        .d_ready(d_ready), .rdata(rdata), .backpressure(backpressure));
    bus_slave #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .req_valid(v0), .req_write(w0),
        .req_addr(a0), .req_wdata(wd0), .a_ready(ar0),
        .d_ready(dr0), .rdata(rd0), .backpressure(bp0));
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    int left;
    logic m_wr;
    logic [5:0] m_idx;
    logic [31:0] m_wd, m_rd;
    logic [31:0] m_mem [DEPTH];
    always @(posedge clk or posedge reset)
        if (reset) begin
            left <= 0;
            m_rd <= '0;
            for (int i = 0; i < DEPTH; i++) m_mem[i] <= '0;
        end else if (left == 0) begin
            if (req_valid) begin
                left <= W + 1;
                m_wr <= req_write;
                m_idx <= req_addr[7:2];
                m_wd <= req_wdata;
                if (W == 0 && !req_write) m_rd <= m_mem[req_addr[7:2]];
            end
        end else begin
            left <= left - 1;
            if (left == 2 && !m_wr) m_rd <= m_mem[m_idx];
            if (left == 1 && m_wr) m_mem[m_idx] <= m_wd;
        end
    always @(negedge clk)
        if (started) begin
            chk("model a_ready", {31'd0, a_ready}, {31'd0, left == 0 && !reset});
            chk("model d_ready", {31'd0, d_ready}, {31'd0, left == 1});
            chk("model backpressure", {31'd0, backpressure}, {31'd0, left > 0});
            chk("model rdata", rdata, m_rd);
        end
    task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wd, output logic [31:0] rd);
        int k;
        k = 0;
        while (!a_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!a_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept timeout: a_ready got 0 expected 1");
        end
        req_valid = 1'b1;
        req_write = wr;
        req_addr = addr;
        req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        k = 1;
        while (!d_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("latency", k, W + 1);
        rd = rdata;
        @(negedge clk);
    endtask
    initial begin
        logic [31:0] rd, r;
        started = 1'b1;
        @(negedge clk);
        #2;
        chk("reset a_ready", {31'd0, a_ready}, 32'd0);
        chk("reset rdata", rdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("first a_ready", {31'd0, a_ready}, 32'd1);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr = 32'h10;
        req_wdata = 32'hDEADBEEF;
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            chk("wr bp", {31'd0, backpressure}, {31'd0, c <= 3});
            chk("wr d_ready", {31'd0, d_ready}, {31'd0, c == 3});
            chk("wr a_ready", {31'd0, a_ready}, {31'd0, c == 4});
            if (c < 4) @(negedge clk);
        end
        txn(1'b0, 32'h10, 32'h0, rd);
        chk("read 0x10", rd, 32'hDEADBEEF);
        txn(1'b0, 32'h04, 32'h0, rd);
        chk("read 0x04", rd, 32'h0);
        txn(1'b1, 32'h100, 32'h12345678, rd);
        txn(1'b0, 32'h000, 32'h0, rd);
        chk("wrap read", rd, 32'h12345678);
        txn(1'b0, 32'h13, 32'h0, rd);
        chk("low bits ignored", rd, 32'hDEADBEEF);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr = 32'h20;
        req_wdata = 32'hCAFEF00D;
        @(negedge clk);
        req_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("abort a_ready", {31'd0, a_ready}, 32'd0);
        chk("abort d_ready", {31'd0, d_ready}, 32'd0);
        chk("abort bp", {31'd0, backpressure}, 32'd0);
        chk("abort rdata", rdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        txn(1'b0, 32'h20, 32'h0, rd);
        chk("aborted write", rd, 32'h0);
        txn(1'b0, 32'h10, 32'h0, rd);
        chk("mem cleared", rd, 32'h0);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr = 32'h30;
        req_wdata = 32'h0000AAAA;
        @(negedge clk);
        req_addr = 32'h34;
        req_wdata = 32'h0000BBBB;
        for (int c = 1; c <= 3; c++) begin
            chk("held a_ready", {31'd0, a_ready}, 32'd0);
            if (c == 3) req_valid = 1'b0;
            @(negedge clk);
        end
        txn(1'b0, 32'h30, 32'h0, rd);
        chk("held first data", rd, 32'h0000AAAA);
        txn(1'b0, 32'h34, 32'h0, rd);
        chk("held no second", rd, 32'h0);
        chk("w0 a_ready", {31'd0, ar0}, 32'd1);
        v0 = 1'b1;
        w0 = 1'b1;
        a0 = 32'h8;
        wd0 = 32'h55;
        @(negedge clk);
        v0 = 1'b0;
        chk("w0 wr d_ready", {31'd0, dr0}, 32'd1);
        @(negedge clk);
        v0 = 1'b1;
        w0 = 1'b0;
        @(negedge clk);
        v0 = 1'b0;
        chk("w0 rd d_ready", {31'd0, dr0}, 32'd1);
        chk("w0 rd a_ready", {31'd0, ar0}, 32'd0);
        chk("w0 rd bp", {31'd0, bp0}, 32'd1);
        chk("w0 rdata", rd0, 32'h55);
        @(negedge clk);
        chk("w0 a_ready after", {31'd0, ar0}, 32'd1);
        chk("w0 d_ready after", {31'd0, dr0}, 32'd0);
        for (int n = 0; n < 600; n++) begin
            r = $urandom;
            req_valid = $urandom_range(0, 1) == 1;
            req_write = $urandom_range(0, 2) == 0;
            req_addr = {r[31:8], 3'b000, 3'($urandom_range(0, 7)), r[1:0]};
            req_wdata = $urandom;
            if ($urandom_range(0, 59) == 0) begin
                #3 reset = 1'b1;
                @(posedge clk);
                #3 reset = 1'b0;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/bus_slave.md
BUS_SLAVE -- requirements
Module: bus_slave

Interface
REQ-001 SHALL have parameter DEPTH, default 64, number of 32-bit memory words (power of 2).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, wait states inserted between address accept and data phase (0..15).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  1  the master presents a request this cycle.
REQ-006 req_write  input  1  1 = write, 0 = read; qualified by req_valid.
REQ-007 req_addr  input  32  byte address; word index = req_addr[log2(DEPTH)+1:2].
REQ-008 req_wdata  input  32  write data; sampled at address accept.
REQ-009 a_ready  output  1  the slave accepts the address phase this cycle.
REQ-010 d_ready  output  1  data phase complete this cycle; rdata valid for reads.
REQ-011 rdata  output  32  read data.
REQ-012 backpressure  output  1  the slave is busy; the master must hold its next request.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, DATA, held in a state register.
REQ-014 SHALL drive a_ready = (state==IDLE) && !reset; this is the only point where a request is accepted.
REQ-015 SHALL accept a request when req_valid && a_ready at a rising edge, latching write flag, word index and wdata.
REQ-016 On accept SHALL go to WAIT with counter=WAIT_CYCLES-1 if WAIT_CYCLES>0, else directly to DATA.
REQ-017 In WAIT, SHALL decrement the counter each cycle and go to DATA when the counter is 0, giving exactly WAIT_CYCLES WAIT cycles.
REQ-018 DATA SHALL last exactly one cycle with d_ready=1, then return to IDLE.
REQ-019 d_ready SHALL assert in cycle A+WAIT_CYCLES+1, where A is the accept cycle.
REQ-020 Throughput SHALL be one transaction per WAIT_CYCLES+2 cycles; IDLE lasts at least one cycle between transactions.
REQ-021 backpressure SHALL be 1 in WAIT and DATA and 0 in IDLE.
REQ-022 For a read, rdata SHALL be loaded from the latched index on entry to DATA and held until the next read's DATA cycle.
REQ-023 For a read, rdata SHALL be valid while d_ready=1.
REQ-024 For a write, the memory word SHALL update at the edge ending the DATA cycle.
REQ-025 For a write, rdata SHALL be unchanged.
REQ-026 A read accepted after a write completes to the same word SHALL return the new data.
REQ-027 Request inputs SHALL be ignored outside IDLE; changes to them during WAIT/DATA SHALL have no effect.
REQ-028 Address bits above the index SHALL be ignored, so addresses wrap modulo DEPTH words.
REQ-029 req_addr[1:0] SHALL be ignored; there are no byte enables.
REQ-030 d_ready and backpressure SHALL never assert in IDLE.
REQ-031 a_ready and d_ready SHALL never assert in the same cycle.

Reset
REQ-032 While reset=1, SHALL force state=IDLE, counter=0, a_ready=0, d_ready=0, backpressure=0 and rdata=0, independent of clk.
REQ-033 While reset=1, SHALL clear all memory words to 0.
REQ-034 A reset asserted mid-transaction SHALL abort it with no memory write, including reset during DATA before its closing edge.
REQ-035 After reset deasserts, a_ready SHALL be 1 in the first cycle.
REQ-036 After reset deasserts, a request SHALL be accepted at the first rising edge.

Verification
REQ-037 WAIT_CYCLES=2: write 0xDEADBEEF to 0x10 accepted in cycle A -> backpressure=1 in A+1..A+3, d_ready=1 only in A+3, a_ready=1 in A+4; then read 0x10 -> rdata=0xDEADBEEF with d_ready.
REQ-038 Read of 0x04 after reset -> rdata=0x00000000 with d_ready, 3 cycles after accept.
REQ-039 DEPTH=64: write 0x12345678 to 0x100, then read 0x000 -> rdata=0x12345678 (wrap).
REQ-040 Hold req_valid=1 and change req_addr/req_wdata during WAIT -> no second accept until a_ready=1; the first transaction's data is unchanged.
REQ-041 Assert reset during WAIT of a write to 0x20 -> all outputs 0 immediately; after release, read 0x20 returns 0.
REQ-042 WAIT_CYCLES=0: read accepted in cycle A -> d_ready=1 in A+1, a_ready=1 in A+2.
